// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 types for the SRAM responder: response codes and FSM state encodings.
package ysyx_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  localparam int WORD_BYTES = 8;

endpackage

// File: rtl/ysyx_sram_1r1w.sv
// 64-bit wide SRAM: one synchronous read port with a registered output, one byte-masked write port.
// The array itself has no reset; only the read-data register does. A same-cycle read and write to
// the same word returns the old contents.
module ysyx_sram_1r1w #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata_o,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb
);

  logic [63:0] mem [0:(1<<AW)-1];
  logic [63:0] rdata_q, rdata_d;

  // Read register: clear takes priority so error responses carry zero data.
  always_comb begin
    rdata_d = rdata_q;
    if (rclr)    rdata_d = '0;
    else if (re) rdata_d = mem[raddr];
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // Byte-masked write into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 single-beat responder backed by a 64-bit word SRAM. Independent read and write FSMs;
// out-of-window addresses and bursts are answered with SLVERR without touching the SRAM.
module ysyx_axi4_sram_slave
  import ysyx_axi_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                MEM_AW = 16,
  parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
  parameter int                RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready_o,
  input  logic [3:0]        arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic [63:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  output logic              rlast_o,
  output logic [3:0]        rid_o,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready_o,
  input  logic [3:0]        awid,
  input  logic [7:0]        awlen,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready_o,
  output logic [3:0]        bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready
);

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  // Address decode: word index from the offset above BASE; range is BASE..BASE+8*2^MEM_AW-1.
  logic [ADDR_W-1:0] ar_off, aw_off;
  logic [MEM_AW-1:0] ar_idx, aw_idx;
  logic              ar_err, aw_err;

  assign ar_off = araddr - BASE;
  assign aw_off = awaddr - BASE;
  assign ar_idx = ar_off[MEM_AW+2:3];
  assign aw_idx = aw_off[MEM_AW+2:3];
  assign ar_err = (araddr < BASE) || (ar_off[ADDR_W-1:MEM_AW+3] != '0) || (arlen != 8'd0);
  assign aw_err = (awaddr < BASE) || (aw_off[ADDR_W-1:MEM_AW+3] != '0) || (awlen != 8'd0);

  // Size/burst are informational and the byte lane is chosen by the master via wstrb.
  logic unused_ok;
  assign unused_ok = ^{arsize, arburst, ar_off[2:0], aw_off[2:0]};

  // SRAM port signals
  logic              sram_re, sram_rclr, sram_we;
  logic [MEM_AW-1:0] sram_raddr;

  // ---------------- read channel ----------------
  rd_state_t         rd_state_q, rd_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]        rd_id_q, rd_id_d;
  logic              rd_err_q, rd_err_d;
  logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
  resp_t             rd_resp_q, rd_resp_d;

  // Read FSM: capture AR, wait out the latency, sample SRAM, hold R until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_id_d    = rd_id_q;
    rd_err_d   = rd_err_q;
    rd_idx_d   = rd_idx_q;
    rd_resp_d  = rd_resp_q;
    sram_re    = 1'b0;
    sram_rclr  = 1'b0;
    sram_raddr = rd_idx_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rd_id_d  = arid;
          rd_err_d = ar_err;
          rd_idx_d = ar_idx;
          rd_cnt_d = CNT_W'(RD_LAT - 1);
          if (ar_err) rd_resp_d = SLVERR;
          else        rd_resp_d = OKAY;
          if (RD_LAT == 1) begin
            // Single-cycle latency: sample the SRAM on the AR handshake edge itself.
            sram_raddr = ar_idx;
            sram_re    = !ar_err;
            sram_rclr  = ar_err;
            rd_state_d = R_RESP;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - CNT_W'(1);
        if (rd_cnt_d == '0) begin
          sram_re    = !rd_err_q;
          sram_rclr  = rd_err_q;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_id_q    <= '0;
      rd_err_q   <= 1'b0;
      rd_idx_q   <= '0;
      rd_resp_q  <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_id_q    <= rd_id_d;
      rd_err_q   <= rd_err_d;
      rd_idx_q   <= rd_idx_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  assign arready_o = (rd_state_q == R_IDLE);
  assign rvalid_o  = (rd_state_q == R_RESP);
  assign rlast_o   = rvalid_o;
  assign rid_o     = rd_id_q;
  assign rresp_o   = rd_resp_q;

  // ---------------- write channel ----------------
  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
  logic [3:0]        aw_id_q, aw_id_d;
  logic              aw_err_q, aw_err_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              wlast_q, wlast_d;
  logic [3:0]        bid_q, bid_d;
  resp_t             bresp_q, bresp_d;

  assign bvalid_o  = (wr_state_q == W_RESP);
  assign awready_o = !aw_held_q && !bvalid_o;
  assign wready_o  = !w_held_q && !bvalid_o;

  // Write FSM: collect AW and W in any order, commit one cycle after both are held, then hold B.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_idx_d   = wr_idx_q;
    aw_id_d    = aw_id_q;
    aw_err_d   = aw_err_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    sram_we    = 1'b0;
    if (awvalid && awready_o) begin
      aw_held_d = 1'b1;
      wr_idx_d  = aw_idx;
      aw_id_d   = awid;
      aw_err_d  = aw_err;
    end
    if (wvalid && wready_o) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
      wlast_d  = wlast;
    end
    case (wr_state_q)
      W_IDLE: begin
        if (aw_held_d && w_held_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        sram_we   = !aw_err_q && wlast_q;
        bid_d     = aw_id_q;
        if (aw_err_q || !wlast_q) bresp_d = SLVERR;
        else                      bresp_d = OKAY;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_idx_q   <= '0;
      aw_id_q    <= '0;
      aw_err_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      wr_idx_q   <= wr_idx_d;
      aw_id_q    <= aw_id_d;
      aw_err_q   <= aw_err_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign bid_o   = bid_q;
  assign bresp_o = bresp_q;

  ysyx_sram_1r1w #(.AW(MEM_AW)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .re      (sram_re),
    .rclr    (sram_rclr),
    .raddr   (sram_raddr),
    .rdata_o (rdata_o),
    .we      (sram_we),
    .waddr   (wr_idx_q),
    .wdata   (wdata_q),
    .wstrb   (wstrb_q)
  );

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Scoreboard bench for the AXI4 SRAM responder: expected responses are queued when a request is
// driven and compared when the DUT presents R or B. Inputs change and outputs are sampled on negedge.
module tb_ysyx_axi4_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b0, bready = 1'b0;
  logic [3:0]  arid = '0, awid = '0;
  logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'd1;
  logic [63:0] wdata = '0;
  logic        wlast = 1'b1;
  logic        arready_o, rvalid_o, rlast_o, awready_o, wready_o, bvalid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o, bresp_o;
  logic [3:0]  rid_o, bid_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_axi4_sram_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready_o(arready_o), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rlast_o(rlast_o), .rid_o(rid_o),
    .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready_o(awready_o), .awid(awid), .awlen(awlen),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  typedef struct { logic [63:0] data; logic [1:0] resp; logic [3:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  rexp_t       exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] model [int];
  int          n_chk = 0, n_fail = 0;

  function automatic bit in_rng(logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h0008_0000);
  endfunction

  // Drive AR and queue the expected R beat.
  task automatic rd_issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          output int t0, output bit ok);
    rexp_t e; bit err; int k;
    err = !in_rng(a) || (len != 8'd0);
    k = int'((a - BASE) >> 3);
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    e.data = err ? 64'h0 : (model.exists(k) ? model[k] : 64'h0);
    exp_r.push_back(e);
    ok = 0; t0 = 0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      arvalid = 1'b1; araddr = a; arid = id; arlen = len;
      if (arready_o) begin ok = 1; t0 = cyc; end
      @(posedge clk);
    end
    @(negedge clk); arvalid = 1'b0;
  endtask

  // Drive AW/W (lead>0: W first by lead cycles, lead<0: AW first) and queue the expected B.
  task automatic wr_issue(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [3:0] id, input logic [7:0] len, input logic last,
                          input int lead, output int t0, output bit ok);
    bexp_t e; bit err, aw_done, w_done, aw_hs, w_hs; int k, aw_s, w_s; logic [63:0] w;
    err = !in_rng(a) || (len != 8'd0) || !last;
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    exp_b.push_back(e);
    if (!err) begin
      k = int'((a - BASE) >> 3);
      w = model.exists(k) ? model[k] : 64'h0;
      for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[k] = w;
    end
    aw_s = (lead > 0) ? lead : 0;
    w_s  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; t0 = 0;
    for (int c = 0; c < 30 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      awvalid = !aw_done && (c >= aw_s);
      wvalid  = !w_done && (c >= w_s);
      awaddr = a; awid = id; awlen = len; wdata = d; wstrb = s; wlast = last;
      aw_hs = awvalid && awready_o;
      w_hs  = wvalid && wready_o;
      if (aw_hs || w_hs) t0 = cyc;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
    end
    ok = aw_done && w_done;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b1;
  endtask

  // Wait (bounded) for rvalid_o or bvalid_o; called on a negedge.
  task automatic wait_valid(input bit is_r, output bit ok, output int seen);
    ok = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (is_r ? rvalid_o : bvalid_o) begin ok = 1; seen = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic hs(input bit is_r);
    if (is_r) rready = 1'b1; else bready = 1'b1;
    @(posedge clk);
    @(negedge clk); rready = 1'b0; bready = 1'b0;
  endtask

  // Full read: returns latency (-1 on timeout) and the observed beat, then completes the handshake.
  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         output int lat, output logic [63:0] d, output logic [1:0] rs,
                         output logic [3:0] ri, output logic rl);
    int t0, seen; bit ok1, ok2;
    rd_issue(a, id, len, t0, ok1);
    wait_valid(1'b1, ok2, seen);
    lat = (ok1 && ok2) ? seen - t0 : -1;
    d = rdata_o; rs = rresp_o; ri = rid_o; rl = rlast_o;
    if (ok2) hs(1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [3:0] id, input logic [7:0] len, input logic last,
                          input int lead, output int lat, output logic [1:0] rs,
                          output logic [3:0] bi);
    int t0, seen; bit ok1, ok2;
    wr_issue(a, d, s, id, len, last, lead, t0, ok1);
    wait_valid(1'b0, ok2, seen);
    lat = (ok1 && ok2) ? seen - t0 : -1;
    rs = bresp_o; bi = bid_o;
    if (ok2) hs(1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if ({arready_o, awready_o, wready_o} !== 3'b111) begin n_fail++;
      $display("FAIL reset_ready act=%b exp=111", {arready_o, awready_o, wready_o}); end
    n_chk++; if ({rvalid_o, rlast_o, bvalid_o} !== 3'b000) begin n_fail++;
      $display("FAIL reset_valid act=%b exp=000", {rvalid_o, rlast_o, bvalid_o}); end
    n_chk++; if (rdata_o !== 64'h0) begin n_fail++;
      $display("FAIL reset_rdata act=%h exp=0", rdata_o); end
    n_chk++; if ({rid_o, bid_o, rresp_o, bresp_o} !== 12'h0) begin n_fail++;
      $display("FAIL reset_ids act=%h exp=000", {rid_o, bid_o, rresp_o, bresp_o}); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] d; logic [1:0] rs; logic [3:0] id; logic rl; bexp_t eb; rexp_t er;
    do_write(BASE + 32'd8, 64'h1122334455667788, 8'hFF, 4'd3, 8'd0, 1'b1, 0, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL wr_latency act=%0d exp=2", lat); end
    n_chk++; if ({rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL wr_bresp_bid act=%h/%h exp=%h/%h", rs, id, eb.resp, eb.id); end
    do_read(BASE + 32'd8, 4'd5, 8'd0, lat, d, rs, id, rl);
    er = exp_r.pop_front();
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency act=%0d exp=2", lat); end
    n_chk++; if (d !== er.data) begin n_fail++; $display("FAIL rd_data act=%h exp=%h", d, er.data); end
    n_chk++; if ({rs, id, rl} !== {er.resp, er.id, 1'b1}) begin n_fail++;
      $display("FAIL rd_resp_id_last act=%h/%h/%b exp=%h/%h/1", rs, id, rl, er.resp, er.id); end
  endtask

  task automatic test_masked_write();
    int lat; logic [63:0] d; logic [1:0] rs; logic [3:0] id; logic rl; bexp_t eb; rexp_t er;
    do_write(BASE + 32'd8, 64'hAAAAAAAABBBBBBBB, 8'h0F, 4'd7, 8'd0, 1'b1, 3, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if (lat != 2 || {rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL mask_b act=%0d/%h/%h exp=2/%h/%h", lat, rs, id, eb.resp, eb.id); end
    do_read(BASE + 32'd8, 4'd1, 8'd0, lat, d, rs, id, rl);
    er = exp_r.pop_front();
    n_chk++; if (d !== er.data || d !== 64'h11223344BBBBBBBB) begin n_fail++;
      $display("FAIL mask_rdata act=%h exp=11223344bbbbbbbb", d); end
  endtask

  task automatic test_errors();
    int lat; logic [63:0] d; logic [1:0] rs; logic [3:0] id; logic rl; bexp_t eb; rexp_t er;
    logic [31:0] ra [4];
    ra[0] = BASE - 32'd8; ra[1] = BASE + 32'h0008_0000; ra[2] = BASE + 32'd8; ra[3] = BASE + 32'h7FFF8;
    // Writes: burst length, missing wlast, zero strobe, last word of the window
    do_write(BASE + 32'd8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 4'd9, 8'd3, 1'b1, -1, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if ({rs, id} !== {eb.resp, eb.id} || rs !== 2'b10) begin n_fail++;
      $display("FAIL wr_awlen_err act=%h/%h exp=%h/%h", rs, id, eb.resp, eb.id); end
    do_write(BASE + 32'd8, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 4'd10, 8'd0, 1'b0, 0, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if ({rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL wr_wlast_err act=%h/%h exp=%h/%h", rs, id, eb.resp, eb.id); end
    do_write(BASE + 32'd8, 64'h0, 8'h00, 4'd11, 8'd0, 1'b1, 1, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if ({rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL wr_zero_strb act=%h/%h exp=%h/%h", rs, id, eb.resp, eb.id); end
    do_write(BASE + 32'h7FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'd12, 8'd0, 1'b1, 0, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if ({rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL wr_top_word act=%h/%h exp=%h/%h", rs, id, eb.resp, eb.id); end
    // Reads: below window, just past window, unchanged word, top word
    for (int i = 0; i < 4; i++) begin
      do_read(ra[i], 4'(i + 2), 8'd0, lat, d, rs, id, rl);
      er = exp_r.pop_front();
      n_chk++; if ({d, rs, id, rl} !== {er.data, er.resp, er.id, 1'b1}) begin n_fail++;
        $display("FAIL rd_edge%0d act=%h/%h/%h/%b exp=%h/%h/%h/1", i, d, rs, id, rl, er.data, er.resp, er.id); end
    end
    do_read(BASE + 32'd8, 4'd4, 8'd1, lat, d, rs, id, rl);
    er = exp_r.pop_front();
    n_chk++; if ({d, rs, rl} !== {er.data, er.resp, 1'b1}) begin n_fail++;
      $display("FAIL rd_arlen_err act=%h/%h/%b exp=%h/%h/1", d, rs, rl, er.data, er.resp); end
  endtask

  task automatic test_stall();
    int t0, seen; bit ok1, ok2; bexp_t eb; rexp_t er;
    wr_issue(BASE + 32'd24, 64'h5555_6666_7777_8888, 8'hFF, 4'd6, 8'd0, 1'b1, 0, t0, ok1);
    wait_valid(1'b0, ok2, seen);
    eb = exp_b.pop_front();
    n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL stall_b_timeout act=%b exp=1", ok1 && ok2); end
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({bvalid_o, bresp_o, bid_o, awready_o, wready_o} !== {1'b1, eb.resp, eb.id, 2'b00}) begin
        n_fail++; $display("FAIL stall_b%0d act=%b/%h/%h/%b%b exp=1/%h/%h/00", i, bvalid_o, bresp_o, bid_o,
                           awready_o, wready_o, eb.resp, eb.id); end
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    hs(1'b0);
    n_chk++; if ({awready_o, wready_o, bvalid_o} !== 3'b110) begin n_fail++;
      $display("FAIL post_b_ready act=%b exp=110", {awready_o, wready_o, bvalid_o}); end
    rd_issue(BASE + 32'd24, 4'd8, 8'd0, t0, ok1);
    wait_valid(1'b1, ok2, seen);
    er = exp_r.pop_front();
    n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL stall_r_timeout act=%b exp=1", ok1 && ok2); end
    arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({rvalid_o, rlast_o, rdata_o, rresp_o, rid_o, arready_o} !== {2'b11, er.data, er.resp, er.id, 1'b0}) begin
        n_fail++; $display("FAIL stall_r%0d act=%b%b/%h/%h/%h/%b exp=11/%h/%h/%h/0", i, rvalid_o, rlast_o,
                           rdata_o, rresp_o, rid_o, arready_o, er.data, er.resp, er.id); end
      @(negedge clk);
    end
    arvalid = 1'b0;
    hs(1'b1);
    n_chk++; if ({arready_o, rvalid_o} !== 2'b10) begin n_fail++;
      $display("FAIL post_r_ready act=%b exp=10", {arready_o, rvalid_o}); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] d; logic [1:0] rs; logic [3:0] id; logic rl; bexp_t eb; rexp_t er;
    logic [31:0] a [5];
    for (int i = 0; i < 5; i++) begin
      a[i] = BASE + 32'(8 * (32 + i));
      do_write(a[i], {$urandom, $urandom}, 8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)),
               8'd0, 1'b1, $urandom_range(0, 4) - 2, lat, rs, id);
      eb = exp_b.pop_front();
      n_chk++; if (lat != 2 || {rs, id} !== {eb.resp, eb.id}) begin n_fail++;
        $display("FAIL b2b_wr%0d act=%0d/%h/%h exp=2/%h/%h", i, lat, rs, id, eb.resp, eb.id); end
    end
    for (int i = 0; i < 5; i++) begin
      do_read(a[i], 4'(i), 8'd0, lat, d, rs, id, rl);
      er = exp_r.pop_front();
      n_chk++; if (lat != 2 || {d, rs, id} !== {er.data, er.resp, er.id}) begin n_fail++;
        $display("FAIL b2b_rd%0d act=%0d/%h/%h/%h exp=2/%h/%h/%h", i, lat, d, rs, id, er.data, er.resp, er.id); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] d; logic [1:0] rs; logic [3:0] id; logic rl; rexp_t er; bexp_t eb;
    @(negedge clk);
    araddr = BASE + 32'd8; arid = 4'd1; arlen = 8'd0; arvalid = 1'b1;
    awaddr = BASE + 32'd16; awid = 4'd2; awlen = 8'd0; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk); arvalid = 1'b0; awvalid = 1'b0;
    n_chk++; if ({arready_o, rvalid_o, awready_o, wready_o} !== 4'b0001) begin n_fail++;
      $display("FAIL pre_rst_state act=%b exp=0001", {arready_o, rvalid_o, awready_o, wready_o}); end
    rst = 1'b1;
    #1;
    n_chk++; if ({rvalid_o, bvalid_o, arready_o, awready_o, wready_o} !== 5'b00111) begin n_fail++;
      $display("FAIL mid_rst act=%b exp=00111", {rvalid_o, bvalid_o, arready_o, awready_o, wready_o}); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if ({rvalid_o, bvalid_o} !== 2'b00) begin n_fail++;
        $display("FAIL post_rst_quiet%0d act=%b exp=00", i, {rvalid_o, bvalid_o}); end
    end
    do_read(BASE + 32'd8, 4'd13, 8'd0, lat, d, rs, id, rl);
    er = exp_r.pop_front();
    n_chk++; if (lat != 2 || {d, rs, id} !== {er.data, er.resp, er.id}) begin n_fail++;
      $display("FAIL post_rst_rd act=%0d/%h/%h/%h exp=2/%h/%h/%h", lat, d, rs, id, er.data, er.resp, er.id); end
    do_write(BASE + 32'd16, 64'h9999_8888_7777_6666, 8'hF0, 4'd14, 8'd0, 1'b1, 0, lat, rs, id);
    eb = exp_b.pop_front();
    n_chk++; if (lat != 2 || {rs, id} !== {eb.resp, eb.id}) begin n_fail++;
      $display("FAIL post_rst_wr act=%0d/%h/%h exp=2/%h/%h", lat, rs, id, eb.resp, eb.id); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
